// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared memory-access definitions for the store buffer.
//   DWORD_IDX_W  double-word index width (byte address bits [12:3])
//   MASK_W       byte-mask width of a double-word access
//   mem_width_e  access width codes of the memory stage
package store_buffer_pkg;
    localparam int DWORD_IDX_W = 10;
    localparam int MASK_W      = 8;
    localparam int SB_DATA_W   = 64;
    localparam int SB_DEPTH    = 4;

    typedef enum logic [1:0] {
        MEM_WIDTH_B = 2'd0,
        MEM_WIDTH_H = 2'd1,
        MEM_WIDTH_W = 2'd2,
        MEM_WIDTH_D = 2'd3
    } mem_width_e;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: memory-stage and RAM-port signals of the store buffer.
//   slave  modport: the store buffer (takes stage/RAM inputs, drives RAM/stage outputs)
//   master modport: the environment (memory stage + data RAM)
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int ADDR_W = DWORD_IDX_W,
    parameter int DATA_W = SB_DATA_W,
    parameter int DEPTH  = SB_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]   addr_in;
    logic [DATA_W-1:0]   wr_data_in;
    logic [DATA_W/8-1:0] mask_in;
    logic                read_signal_in;
    logic                write_signal_in;
    logic                fence_in;
    logic [DATA_W-1:0]   ram_data_in;
    logic [ADDR_W-1:0]   ram_addr_out;
    logic [DATA_W-1:0]   ram_wr_data_out;
    logic [DATA_W/8-1:0] ram_mask_out;
    logic                ram_write_out;
    logic                ram_read_out;
    logic [DATA_W-1:0]   data_read_value_out;
    logic                stall_request_out;
    logic                empty_out;
    logic [CNT_W-1:0]    count_out;

    modport slave (
        input  addr_in, wr_data_in, mask_in, read_signal_in, write_signal_in,
               fence_in, ram_data_in,
        output ram_addr_out, ram_wr_data_out, ram_mask_out, ram_write_out,
               ram_read_out, data_read_value_out, stall_request_out, empty_out,
               count_out
    );

    modport master (
        output addr_in, wr_data_in, mask_in, read_signal_in, write_signal_in,
               fence_in, ram_data_in,
        input  ram_addr_out, ram_wr_data_out, ram_mask_out, ram_write_out,
               ram_read_out, data_read_value_out, stall_request_out, empty_out,
               count_out
    );
endinterface

// File: rtl/store_buffer_byte_merge.sv
// store_buffer_byte_merge: overlays the masked bytes of data onto base.
//   base    in  word being merged into
//   data    in  overlay word
//   mask    in  byte enables; 1 selects data for that lane
//   merged  out result
module store_buffer_byte_merge #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]   base,
    input  logic [DATA_W-1:0]   data,
    input  logic [DATA_W/8-1:0] mask,
    output logic [DATA_W-1:0]   merged
);
    for (genvar k = 0; k < DATA_W/8; k++) begin : g_lane
        assign merged[8*k +: 8] = mask[k] ? data[8*k +: 8] : base[8*k +: 8];
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between the memory stage and the byte-masked data RAM.
// Stores are queued and drained to the RAM whenever a load is not using the port;
// loads see buffered bytes merged over the RAM read data.
//   clk_in  clock (rising edge)
//   rst_in  asynchronous active-high reset
//   bus     store_buffer_if.slave: stage request, RAM port, stall/empty/count status
// Build option: STORE_BUF_FWD_EN enables load forwarding from buffered entries;
// without it a load hitting a buffered index stalls until that index has drained.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = DWORD_IDX_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic         clk_in,
    input  logic         rst_in,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MW    = DATA_W / 8;

    logic [ADDR_W-1:0] idx_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [MW-1:0]     mask_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;

    logic             empty, full, fence_blk, hit, load_blk, rd_go, drain, accept, stall;
    logic [DEPTH-1:0] match;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign fence_blk = bus.fence_in && !empty;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++)
            match[i] = vld_q[i] && (idx_q[i] == bus.addr_in);
    end
    assign hit = |match;

`ifdef STORE_BUF_FWD_EN
    assign load_blk = fence_blk;
    assign stall    = (bus.write_signal_in && full) || fence_blk;
`else
    // A store in the same cycle wins over the load, so a hit only matters for a pure load.
    assign load_blk = fence_blk || (hit && !bus.write_signal_in);
    assign stall    = (bus.write_signal_in && full) || fence_blk ||
                      (bus.read_signal_in && !bus.write_signal_in && hit);
`endif

    assign rd_go  = bus.read_signal_in && !load_blk;
    assign drain  = !empty && !rd_go;
    // A stalled store is re-presented next cycle, so it must not also be taken now.
    assign accept = bus.write_signal_in && !full && !fence_blk;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld_q <= '0;
        end else begin
            if (accept) begin
                vld_q[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            if (drain) begin
                vld_q[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(accept) - CNT_W'(drain);
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            idx_q[tail]  <= bus.addr_in;
            data_q[tail] <= bus.wr_data_in;
            mask_q[tail] <= bus.mask_in;
        end
    end

`ifdef STORE_BUF_FWD_EN
    // Merge chain walks slots oldest (head) to youngest so later stores win per byte.
    logic [DEPTH:0][DATA_W-1:0] chain;
    assign chain[0] = bus.ram_data_in;
    for (genvar i = 0; i < DEPTH; i++) begin : g_merge
        logic [PTR_W-1:0] slot;
        logic [MW-1:0]    sel;
        assign slot = head + PTR_W'(i);
        assign sel  = match[slot] ? mask_q[slot] : '0;
        store_buffer_byte_merge #(.DATA_W(DATA_W)) u_merge (
            .base  (chain[i]),
            .data  (data_q[slot]),
            .mask  (sel),
            .merged(chain[i+1])
        );
    end
    assign bus.data_read_value_out = chain[DEPTH];
`else
    assign bus.data_read_value_out = bus.ram_data_in;
`endif

    assign bus.ram_addr_out      = rd_go ? bus.addr_in : idx_q[head];
    assign bus.ram_wr_data_out   = data_q[head];
    assign bus.ram_mask_out      = mask_q[head];
    assign bus.ram_write_out     = drain;
    assign bus.ram_read_out      = rd_go;
    assign bus.stall_request_out = stall;
    assign bus.empty_out         = empty;
    assign bus.count_out         = count;
endmodule
